// File: rtl/acc_lut_pkg.sv
// Shared types and default-constant table for the accumulator constant LUT.
package acc_lut_pkg;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } lut_state_e;

   localparam int unsigned K_MAX   = 0;
   localparam int unsigned K_MASK  = 1;
   localparam int unsigned K_ZERO  = 2;
   localparam int unsigned K_ONE   = 3;
   localparam int unsigned K_BASE  = 4;
   localparam int unsigned K_BASE1 = 5;
   localparam int unsigned K_BASE2 = 6;

   // Computed at 64 bits; callers cast down to their VAL_W.
   function automatic logic [63:0] acc_default(input int unsigned key, input int unsigned val_w);
      logic [63:0] base;
      logic [63:0] ones;
      base = 64'd1 << (val_w - 2);
      ones = (64'd1 << val_w) - 64'd1;
      case (key)
         K_MAX:   return ones;
         K_MASK:  return base - 64'd1;
         K_ZERO:  return 64'd0;
         K_ONE:   return 64'd1;
         K_BASE:  return base;
         K_BASE1: return base + 64'd1;
         K_BASE2: return base + 64'd2;
         default: return 64'd0;
      endcase
   endfunction

endpackage

// File: rtl/acc_lut_ram_if.sv
// Request/response bundle between the accumulator control and the constant LUT.
interface acc_lut_ram_if #(
   parameter int KEY_W = 5,
   parameter int VAL_W = 8
);
   logic             en;
   logic             restore;
   logic             rd_en;
   logic [KEY_W-1:0] rd_key;
   logic [VAL_W-1:0] rd_value;
   logic             rd_valid;
   logic             rd_miss;
   logic             wr_en;
   logic [KEY_W-1:0] wr_key;
   logic [VAL_W-1:0] wr_value;
   logic             ready;

   modport master (
      output en, restore, rd_en, rd_key, wr_en, wr_key, wr_value,
      input  rd_value, rd_valid, rd_miss, ready
   );

   modport slave (
      input  en, restore, rd_en, rd_key, wr_en, wr_key, wr_value,
      output rd_value, rd_valid, rd_miss, ready
   );
endinterface

// File: rtl/acc_lut_default.sv
// Combinational key -> architectural default constant, feeding the INIT walker.
module acc_lut_default
   import acc_lut_pkg::*;
#(
   parameter int KEY_W = 6,
   parameter int VAL_W = 8
) (
   input  logic [KEY_W-1:0] key,
   output logic [VAL_W-1:0] value
);

   always_comb begin
      value = VAL_W'(acc_default(32'(key), VAL_W));
   end

endmodule

// File: rtl/acc_lut_ram.sv
// Writable constant LUT: self-initialises to defaults, then serves 1-cycle reads and runtime writes.
//   state | meaning
//   INIT  | walker writes default(init_ptr) into every entry; requests dropped
//   READY | reads/writes accepted; restore re-enters INIT
module acc_lut_ram
   import acc_lut_pkg::*;
#(
   parameter int KEY_W = 5,
   parameter int VAL_W = 8,
   parameter int DEPTH = 32
) (
   input  logic          clk,
   input  logic          reset,
   acc_lut_ram_if.slave  bus
);

   localparam int PTR_W  = $clog2(DEPTH) + 1;
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [KEY_W:0]   DEPTH_K  = (KEY_W + 1)'(DEPTH);

   logic [VAL_W-1:0] mem [DEPTH];

   lut_state_e       state_q, state_nxt;
   logic [PTR_W-1:0] init_ptr_q, init_ptr_nxt;
   logic [VAL_W-1:0] init_value;
   logic             init_we;
   logic             rd_accept, wr_accept;
   logic             rd_in_range, wr_in_range;
   logic             rd_valid_q, rd_valid_nxt;
   logic             rd_miss_q, rd_miss_nxt;
   logic [VAL_W-1:0] rd_value_q, rd_value_nxt;

   acc_lut_default #(
      .KEY_W (PTR_W),
      .VAL_W (VAL_W)
   ) u_default (
      .key   (init_ptr_q),
      .value (init_value)
   );

   assign rd_in_range = ({1'b0, bus.rd_key} < DEPTH_K);
   assign wr_in_range = ({1'b0, bus.wr_key} < DEPTH_K);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= INIT;
         init_ptr_q <= '0;
         rd_valid_q <= 1'b0;
         rd_miss_q  <= 1'b0;
         rd_value_q <= '0;
      end else begin
         state_q    <= state_nxt;
         init_ptr_q <= init_ptr_nxt;
         rd_valid_q <= rd_valid_nxt;
         rd_miss_q  <= rd_miss_nxt;
         rd_value_q <= rd_value_nxt;
      end
   end

   // Storage has no reset; INIT rewrites every implemented entry.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (init_we) begin
            mem[init_ptr_q[ADDR_W-1:0]] <= init_value;
         end else if (wr_accept) begin
            mem[bus.wr_key[ADDR_W-1:0]] <= bus.wr_value;
         end
      end
   end

   always_comb begin
      state_nxt    = state_q;
      init_ptr_nxt = init_ptr_q;
      init_we      = 1'b0;
      rd_accept    = 1'b0;
      wr_accept    = 1'b0;
      case (state_q)
         INIT: begin
            init_we      = 1'b1;
            init_ptr_nxt = init_ptr_q + PTR_W'(1);
            if (init_ptr_q == LAST_PTR) begin
               state_nxt = READY;
            end
         end
         READY: begin
            if (bus.restore) begin
               state_nxt    = INIT;
               init_ptr_nxt = '0;
            end else begin
               rd_accept = bus.rd_en && bus.en;
               wr_accept = bus.wr_en && wr_in_range;
            end
         end
         default: state_nxt = INIT;
      endcase
   end

   // Write-first: a same-cycle write to the read key bypasses the array.
   always_comb begin
      rd_valid_nxt = rd_accept;
      rd_miss_nxt  = rd_accept && !rd_in_range;
      rd_value_nxt = '0;
      if (rd_accept && rd_in_range) begin
         if (wr_accept && (bus.wr_key == bus.rd_key)) begin
            rd_value_nxt = bus.wr_value;
         end else begin
            rd_value_nxt = mem[bus.rd_key[ADDR_W-1:0]];
         end
      end
   end

   assign bus.ready    = (state_q == READY);
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_miss  = rd_miss_q;
   assign bus.rd_value = rd_value_q;

endmodule

// File: tb/tb_acc_lut_ram.sv
// Scoreboard bench for acc_lut_ram: default and DEPTH=16 instances share clock and reset.
module tb_acc_lut_ram;

   logic clk;
   logic reset;

   acc_lut_ram_if #(.KEY_W(5), .VAL_W(8)) b   ();
   acc_lut_ram_if #(.KEY_W(5), .VAL_W(8)) b16 ();

   acc_lut_ram #(.KEY_W(5), .VAL_W(8), .DEPTH(32)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (b)
   );

   acc_lut_ram #(.KEY_W(5), .VAL_W(8), .DEPTH(16)) u_dut16 (
      .clk   (clk),
      .reset (reset),
      .bus   (b16)
   );

   typedef struct {
      logic [7:0] val;
      logic       miss;
      int         tag;
   } exp_t;

   exp_t exp_q[$];
   exp_t exp16_q[$];
   int   checks = 0;
   int   errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // Monitors: pop one expectation per rd_valid pulse.
   always @(negedge clk) begin
      if (b.rd_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid main value=%0d miss=%0b required no rd_valid", b.rd_value, b.rd_miss);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (b.rd_value !== e.val || b.rd_miss !== e.miss) begin
               errors++;
               $display("FAIL read_%0d main value=%0d miss=%0b required value=%0d miss=%0b",
                        e.tag, b.rd_value, b.rd_miss, e.val, e.miss);
            end
         end
      end
      if (b16.rd_valid === 1'b1) begin
         checks++;
         if (exp16_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid d16 value=%0d miss=%0b required no rd_valid", b16.rd_value, b16.rd_miss);
         end else begin
            exp_t e;
            e = exp16_q.pop_front();
            if (b16.rd_value !== e.val || b16.rd_miss !== e.miss) begin
               errors++;
               $display("FAIL read_%0d d16 value=%0d miss=%0b required value=%0d miss=%0b",
                        e.tag, b16.rd_value, b16.rd_miss, e.val, e.miss);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic rd(input logic [4:0] k, input logic [7:0] v, input int tag);
      b.rd_en  = 1'b1;
      b.rd_key = k;
      exp_q.push_back('{v, 1'b0, tag});
      step();
      b.rd_en = 1'b0;
      chk("rd_latency", {31'd0, b.rd_valid}, 32'd1);
   endtask

   task automatic rd16(input logic [4:0] k, input logic [7:0] v, input logic m, input int tag);
      b16.rd_en  = 1'b1;
      b16.rd_key = k;
      exp16_q.push_back('{v, m, tag});
      step();
      b16.rd_en = 1'b0;
      chk("rd16_latency", {31'd0, b16.rd_valid}, 32'd1);
   endtask

   task automatic wr(input logic [4:0] k, input logic [7:0] v);
      b.wr_en    = 1'b1;
      b.wr_key   = k;
      b.wr_value = v;
      step();
      b.wr_en = 1'b0;
   endtask

   task automatic wait_ready(input string name, input int req_n);
      int n;
      n = 0;
      while (b.ready !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      chk(name, n, req_n);
   endtask

   logic [7:0] def_tab [8];

   initial begin
      int n, n16;
      def_tab[0] = 8'd255; def_tab[1] = 8'd63; def_tab[2] = 8'd0; def_tab[3] = 8'd1;
      def_tab[4] = 8'd64;  def_tab[5] = 8'd65; def_tab[6] = 8'd66; def_tab[7] = 8'd0;

      reset = 1'b1;
      b.en = 1'b1;   b.restore = 1'b0;   b.rd_en = 1'b0;   b.rd_key = '0;
      b.wr_en = 1'b0; b.wr_key = '0;     b.wr_value = '0;
      b16.en = 1'b1; b16.restore = 1'b0; b16.rd_en = 1'b0; b16.rd_key = '0;
      b16.wr_en = 1'b0; b16.wr_key = '0; b16.wr_value = '0;
      step();
      step();
      chk("reset_ready", {31'd0, b.ready}, 32'd0);
      chk("reset_valid", {31'd0, b.rd_valid}, 32'd0);
      chk("reset_value", {24'd0, b.rd_value}, 32'd0);
      chk("reset_miss", {31'd0, b.rd_miss}, 32'd0);

      // Requests during INIT must be dropped.
      reset = 1'b0;
      b.rd_en = 1'b1; b.rd_key = 5'd0;
      n = 0; n16 = -1;
      while (b.ready !== 1'b1 && n < 100) begin
         step();
         n++;
         if (b16.ready === 1'b1 && n16 < 0) n16 = n;
         if (n == 3) b.rd_en = 1'b0;
      end
      chk("init_len_32", n, 32'd32);
      chk("init_len_16", n16, 32'd16);

      for (int k = 0; k < 8; k++) rd(5'(k), def_tab[k], k);

      wr(5'd4, 8'hA5);
      rd(5'd4, 8'hA5, 100);

      // Read presented with restore is dropped.
      b.restore = 1'b1;
      b.rd_en = 1'b1; b.rd_key = 5'd4;
      step();
      b.restore = 1'b0;
      b.rd_en = 1'b0;
      chk("restore_no_valid", {31'd0, b.rd_valid}, 32'd0);
      chk("restore_ready", {31'd0, b.ready}, 32'd0);
      wait_ready("restore_len", 32);
      rd(5'd4, 8'd64, 101);

      b.wr_en = 1'b1; b.wr_key = 5'd2; b.wr_value = 8'h3C;
      rd(5'd2, 8'h3C, 102);
      b.wr_en = 1'b0;
      rd(5'd2, 8'h3C, 103);

      b.en = 1'b0;
      b.rd_en = 1'b1; b.rd_key = 5'd0;
      step();
      b.rd_en = 1'b0;
      chk("en0_valid", {31'd0, b.rd_valid}, 32'd0);
      chk("en0_value", {24'd0, b.rd_value}, 32'd0);
      b.en = 1'b1;
      rd(5'd0, 8'd255, 104);

      rd16(5'd20, 8'd0, 1'b1, 200);
      b16.wr_en = 1'b1; b16.wr_key = 5'd20; b16.wr_value = 8'h77;
      step();
      b16.wr_en = 1'b0;
      for (int k = 0; k < 16; k++) rd16(5'(k), (k < 8) ? def_tab[k] : 8'd0, 1'b0, 210 + k);

      // Reset mid-INIT at init_ptr=10 after overriding key 5.
      wr(5'd5, 8'h12);
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst_init_ready", {31'd0, b.ready}, 32'd0);
      chk("rst_init_valid", {31'd0, b.rd_valid}, 32'd0);
      wait_ready("rst_init_len", 32);
      rd(5'd5, 8'd65, 105);

      // Reset with a read in flight in READY.
      b.rd_en = 1'b1; b.rd_key = 5'd0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      b.rd_en = 1'b0;
      chk("rst_ready_valid", {31'd0, b.rd_valid}, 32'd0);
      chk("rst_ready_ready", {31'd0, b.ready}, 32'd0);
      wait_ready("rst_ready_len", 32);
      rd(5'd6, 8'd66, 106);

      step();
      step();
      chk("drain_main", exp_q.size(), 32'd0);
      chk("drain_d16", exp16_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
